m68k_bus_bridge: RTL

- Sits between the 68000 CPU pins and the word-wide on-chip memory.
- Synchronises the CPU's asynchronous bus strobes (AS_n, UDS_n, LDS_n, R/W) into the clk domain.
- Issues one memory access per CPU bus cycle, waits for the memory ack, then returns DTACK_n with read data.
- Flags BERR_n when no ack arrives within a bounded time.

---
 rtl/m68k_bus_bridge_if.sv | 43 ++++
 rtl/m68k_bus_bridge.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// m68k_bus_bridge_if
// Bundles the 68000 pin-side signals and the word-wide memory port of the
// bus bridge.
//   slave  : bridge view (consumes CPU strobes/addr/data and memory response,
//            drives CPU acknowledge/read data and memory request)
//   master : environment view (CPU pins + memory), the mirror of slave
// CPU strobes are active low and asynchronous; memory strobes are active high.
// ---------------------------------------------------------------------------
interface m68k_bus_bridge_if;
    logic        cpu_as_n;
    logic        cpu_uds_n;
    logic        cpu_lds_n;
    logic        cpu_rw;
    logic [22:0] cpu_addr;
    logic [15:0] cpu_data_in;
    logic [15:0] cpu_data_out;
    logic        cpu_data_oe;
    logic        cpu_dtack_n;
    logic        cpu_berr_n;

    logic [23:0] mem_addr;
    logic [15:0] mem_data_write;
    logic [15:0] mem_data_read;
    logic        mem_uds;
    logic        mem_lds;
    logic        mem_rw;
    logic        mem_ack;

    modport slave (
        input  cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_data_in,
        output cpu_data_out, cpu_data_oe, cpu_dtack_n, cpu_berr_n,
        output mem_addr, mem_data_write, mem_uds, mem_lds, mem_rw,
        input  mem_data_read, mem_ack
    );

    modport master (
        output cpu_as_n, cpu_uds_n, cpu_lds_n, cpu_rw, cpu_addr, cpu_data_in,
        input  cpu_data_out, cpu_data_oe, cpu_dtack_n, cpu_berr_n,
        input  mem_addr, mem_data_write, mem_uds, mem_lds, mem_rw,
        output mem_data_read, mem_ack
    );
endinterface

// File: rtl/m68k_bus_bridge.sv
// ---------------------------------------------------------------------------
// m68k_bus_bridge
// Bridges asynchronous 68000 bus cycles onto a synchronous word-wide memory.
// One memory access is issued per CPU bus cycle; DTACK_n is returned once the
// memory acknowledges, BERR_n if no acknowledge arrives in time.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      m68k_bus_bridge_if.slave (CPU pins + memory port)
//
// Parameters:
//   SYNC_STAGES     depth of the strobe / rw synchronisers (>= 2)
//   TIMEOUT_CYCLES  ACCESS cycles without ack before bus error (1..65535)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | memory strobes low, waiting for AS plus a data strobe
// ACCESS | memory strobes driven, waiting for a qualified ack
// DTACK  | dtack_n low (read data driven on reads), waiting for AS release
// BERR   | berr_n low, strobes dropped, waiting for AS release
// ---------------------------------------------------------------------------
module m68k_bus_bridge #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    m68k_bus_bridge_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DTACK  = 2'd2,
        S_BERR   = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Synchronisers hold the raw pin polarity so reset loads "bus inactive".
    logic [SYNC_STAGES-1:0] as_q, uds_q, lds_q, rw_q;
    logic                   as_s, uds_s, lds_s, rw_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            as_q  <= '1;
            uds_q <= '1;
            lds_q <= '1;
            rw_q  <= '1;
        end else begin
            as_q  <= {as_q[SYNC_STAGES-2:0],  bus.cpu_as_n};
            uds_q <= {uds_q[SYNC_STAGES-2:0], bus.cpu_uds_n};
            lds_q <= {lds_q[SYNC_STAGES-2:0], bus.cpu_lds_n};
            rw_q  <= {rw_q[SYNC_STAGES-2:0],  bus.cpu_rw};
        end
    end

    assign as_s  = ~as_q[SYNC_STAGES-1];
    assign uds_s = ~uds_q[SYNC_STAGES-1];
    assign lds_s = ~lds_q[SYNC_STAGES-1];
    assign rw_s  = rw_q[SYNC_STAGES-1];

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [23:0] addr_q, addr_nxt;
    logic [15:0] wdata_q, wdata_nxt;
    logic        uds_o, uds_nxt;
    logic        lds_o, lds_nxt;
    logic        rw_o, rw_nxt;
    logic [15:0] rdata_q, rdata_nxt;
    logic        oe_q, oe_nxt;
    logic        dtack_n_q, dtack_n_nxt;
    logic        berr_n_q, berr_n_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            uds_o     <= 1'b0;
            lds_o     <= 1'b0;
            rw_o      <= 1'b1;
            rdata_q   <= '0;
            oe_q      <= 1'b0;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            addr_q    <= addr_nxt;
            wdata_q   <= wdata_nxt;
            uds_o     <= uds_nxt;
            lds_o     <= lds_nxt;
            rw_o      <= rw_nxt;
            rdata_q   <= rdata_nxt;
            oe_q      <= oe_nxt;
            dtack_n_q <= dtack_n_nxt;
            berr_n_q  <= berr_n_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        addr_nxt    = addr_q;
        wdata_nxt   = wdata_q;
        uds_nxt     = uds_o;
        lds_nxt     = lds_o;
        rw_nxt      = rw_o;
        rdata_nxt   = rdata_q;
        oe_nxt      = oe_q;
        dtack_n_nxt = dtack_n_q;
        berr_n_nxt  = berr_n_q;

        case (state)
            S_IDLE: begin
                // Address and write data are not synchronised: the CPU keeps
                // them stable for as long as its strobes are asserted.
                if (as_s && (uds_s || lds_s)) begin
                    addr_nxt  = {1'b0, bus.cpu_addr};
                    wdata_nxt = bus.cpu_data_in;
                    uds_nxt   = uds_s;
                    lds_nxt   = lds_s;
                    rw_nxt    = rw_s;
                    cnt_nxt   = '0;
                    state_nxt = S_ACCESS;
                end
            end

            S_ACCESS: begin
                if (!as_s) begin
                    // CPU abandoned the cycle; a write may already be in memory.
                    uds_nxt   = 1'b0;
                    lds_nxt   = 1'b0;
                    rw_nxt    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (cnt != '0 && bus.mem_ack) begin
                    // First ACCESS cycle's ack belongs to the previous address.
                    if (rw_o) begin
                        rdata_nxt = bus.mem_data_read;
                        oe_nxt    = 1'b1;
                    end
                    dtack_n_nxt = 1'b0;
                    state_nxt   = S_DTACK;
                end else if (cnt == TO_LAST) begin
                    berr_n_nxt = 1'b0;
                    uds_nxt    = 1'b0;
                    lds_nxt    = 1'b0;
                    rw_nxt     = 1'b1;
                    state_nxt  = S_BERR;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end

            S_DTACK: begin
                if (!as_s) begin
                    dtack_n_nxt = 1'b1;
                    oe_nxt      = 1'b0;
                    uds_nxt     = 1'b0;
                    lds_nxt     = 1'b0;
                    rw_nxt      = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end

            S_BERR: begin
                if (!as_s) begin
                    berr_n_nxt = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.cpu_data_out   = rdata_q;
    assign bus.cpu_data_oe    = oe_q;
    assign bus.cpu_dtack_n    = dtack_n_q;
    assign bus.cpu_berr_n     = berr_n_q;
    assign bus.mem_addr       = addr_q;
    assign bus.mem_data_write = wdata_q;
    assign bus.mem_uds        = uds_o;
    assign bus.mem_lds        = lds_o;
    assign bus.mem_rw         = rw_o;

endmodule
